// File: rtl/bp_fe_queue_buffer_if.sv
// Handshake bundle between the FE producer / BE scheduler and the speculative FE queue.
// The buffer takes the slave modport; whoever drives FE and BE traffic takes the master modport.
interface bp_fe_queue_buffer_if #(
    parameter int width_p      = 128,
    parameter int ptr_width_lp = 4
);
    logic [width_p-1:0]      fe_queue_i;
    logic                    fe_queue_v_i;
    logic                    fe_queue_ready_o;
    logic [width_p-1:0]      fe_queue_o;
    logic                    fe_queue_v_o;
    logic                    fe_queue_yumi_i;
    logic                    fe_queue_deq_i;
    logic                    fe_queue_roll_i;
    logic                    fe_queue_clr_i;
    logic [ptr_width_lp-1:0] count_o;

    modport master (
        output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i,
               fe_queue_roll_i, fe_queue_clr_i,
        input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o, count_o
    );

    modport slave (
        input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i, fe_queue_deq_i,
               fe_queue_roll_i, fe_queue_clr_i,
        output fe_queue_ready_o, fe_queue_o, fe_queue_v_o, count_o
    );
endinterface

// File: rtl/bp_fe_queue_buffer.sv
// Speculative FE instruction queue: write, speculative-read and commit pointers over one storage array.
// A slot is released only on commit, so a roll can replay anything issued but not yet committed.
module bp_fe_queue_buffer #(
    parameter int els_p   = 8,
    parameter int width_p = 128,
    localparam int ptr_width_lp  = $clog2(els_p) + 1,
    localparam int addr_width_lp = $clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bp_fe_queue_buffer_if.slave      fe_if
);

    logic [ptr_width_lp-1:0] wptr_r, rptr_r, cptr_r;
    logic [ptr_width_lp-1:0] wptr_n, rptr_n, cptr_n;
    logic [ptr_width_lp-1:0] occupancy;
    logic [width_p-1:0]      mem [els_p];
    logic                    full;
    logic                    enq;

    // Wrap bits make wptr - cptr an exact occupancy in 0..els_p.
    assign occupancy = wptr_r - cptr_r;
    assign full      = (occupancy == ptr_width_lp'(els_p));
    assign enq       = fe_if.fe_queue_v_i & ~full & ~fe_if.fe_queue_clr_i;

    assign fe_if.fe_queue_ready_o = ~full;
    assign fe_if.fe_queue_v_o     = (rptr_r != wptr_r);
    assign fe_if.fe_queue_o       = mem[rptr_r[addr_width_lp-1:0]];
    assign fe_if.count_o          = occupancy;

    always_comb begin
        wptr_n = wptr_r + ptr_width_lp'(enq);
        rptr_n = rptr_r;
        cptr_n = cptr_r;
        if (fe_if.fe_queue_clr_i) begin
            wptr_n = wptr_r;
            rptr_n = wptr_r;
            cptr_n = wptr_r;
        end else if (fe_if.fe_queue_roll_i) begin
            // Roll rewinds to the commit point after any same-cycle commit.
            cptr_n = cptr_r + ptr_width_lp'(fe_if.fe_queue_deq_i);
            rptr_n = cptr_n;
        end else begin
            rptr_n = rptr_r + ptr_width_lp'(fe_if.fe_queue_yumi_i);
            cptr_n = cptr_r + ptr_width_lp'(fe_if.fe_queue_deq_i);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r <= '0;
            rptr_r <= '0;
            cptr_r <= '0;
        end else begin
            wptr_r <= wptr_n;
            rptr_r <= rptr_n;
            cptr_r <= cptr_n;
        end
    end

    // Storage carries no reset; pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem[wptr_r[addr_width_lp-1:0]] <= fe_if.fe_queue_i;
        end
    end

`ifndef SYNTHESIS
    yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (fe_if.fe_queue_yumi_i & ~fe_if.fe_queue_clr_i & ~fe_if.fe_queue_roll_i) |-> fe_if.fe_queue_v_o);

    deq_needs_issued: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (fe_if.fe_queue_deq_i & ~fe_if.fe_queue_clr_i) |-> (cptr_r != rptr_r));
`endif

endmodule

// File: tb/tb_bp_fe_queue_buffer.sv
// Directed bench for bp_fe_queue_buffer: queue-based reference model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_bp_fe_queue_buffer;

    localparam int ELS = 8;
    localparam int W   = 128;
    localparam int PW  = 4;

    logic clk;
    logic rst_n;

    bp_fe_queue_buffer_if #(.width_p(W), .ptr_width_lp(PW)) fq ();

    bp_fe_queue_buffer #(.els_p(ELS), .width_p(W)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .fe_if     (fq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: uncommitted packets oldest-first, and how many of them have been issued.
    logic [W-1:0] mq[$];
    int           mrd;
    bit           m_acc;
    logic [W-1:0] m_junk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        mq.delete();
        mrd = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                mrd = 0;
            end else begin
                m_acc = fq.fe_queue_v_i && (mq.size() != ELS);
                if (fq.fe_queue_clr_i) begin
                    mq.delete();
                    mrd = 0;
                end else begin
                    if (fq.fe_queue_roll_i) begin
                        if (fq.fe_queue_deq_i) m_junk = mq.pop_front();
                        mrd = 0;
                    end else begin
                        if (fq.fe_queue_yumi_i) mrd++;
                        if (fq.fe_queue_deq_i) begin
                            m_junk = mq.pop_front();
                            mrd--;
                        end
                    end
                    if (m_acc) mq.push_back(fq.fe_queue_i);
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("m_ready", W'(fq.fe_queue_ready_o), W'(mq.size() != ELS));
                check("m_v",     W'(fq.fe_queue_v_o),     W'(mrd < mq.size()));
                check("m_count", W'(fq.count_o),          W'(mq.size()));
                if (mrd < mq.size()) check("m_data", fq.fe_queue_o, mq[mrd]);
            end
        end
    end

    task automatic step(input bit v, input logic [W-1:0] d, input bit y, input bit dq,
                        input bit rl, input bit cl);
        fq.fe_queue_v_i    = v;
        fq.fe_queue_i      = d;
        fq.fe_queue_yumi_i = y;
        fq.fe_queue_deq_i  = dq;
        fq.fe_queue_roll_i = rl;
        fq.fe_queue_clr_i  = cl;
        @(posedge clk);
        #1;
        fq.fe_queue_v_i    = 1'b0;
        fq.fe_queue_i      = '0;
        fq.fe_queue_yumi_i = 1'b0;
        fq.fe_queue_deq_i  = 1'b0;
        fq.fe_queue_roll_i = 1'b0;
        fq.fe_queue_clr_i  = 1'b0;
    endtask

    task automatic enq(input logic [W-1:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic yumi();
        step(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic deq();
        step(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clr();
        step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int  exp_out;
        bit  y_now;
        bit  y_prev;
        logic [W-1:0] d;

        rst_n = 1'b0;
        fq.fe_queue_v_i    = 1'b0;
        fq.fe_queue_i      = '0;
        fq.fe_queue_yumi_i = 1'b0;
        fq.fe_queue_deq_i  = 1'b0;
        fq.fe_queue_roll_i = 1'b0;
        fq.fe_queue_clr_i  = 1'b0;

        #11;
        check("rst_ready", W'(fq.fe_queue_ready_o), W'(1));
        check("rst_v",     W'(fq.fe_queue_v_o),     W'(0));
        check("rst_count", W'(fq.count_o),          W'(0));
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset then fill
        for (int i = 1; i <= ELS; i++) begin
            check("fill_ready", W'(fq.fe_queue_ready_o), W'(1));
            enq(W'(i));
            if (i == 1) begin
                check("fill_first_v",    W'(fq.fe_queue_v_o), W'(1));
                check("fill_first_data", fq.fe_queue_o,       W'(1));
            end
        end
        check("fill_full_ready", W'(fq.fe_queue_ready_o), W'(0));
        check("fill_full_count", W'(fq.count_o),          W'(8));
        enq(W'('h99));
        check("fill_drop_count", W'(fq.count_o), W'(8));
        clr();
        check("fill_clr_v",     W'(fq.fe_queue_v_o),     W'(0));
        check("fill_clr_count", W'(fq.count_o),          W'(0));
        check("fill_clr_ready", W'(fq.fe_queue_ready_o), W'(1));

        // Issue/commit across the pointer wrap
        exp_out = 1;
        y_prev  = 1'b0;
        for (int c = 0; c < 24; c++) begin
            y_now = (mrd < mq.size());
            if (y_now) begin
                check("wrap_data", fq.fe_queue_o, W'(exp_out));
                exp_out++;
            end
            check("wrap_count_le2", W'(fq.count_o <= 2), W'(1));
            step(c < 20, W'(c + 1), y_now, y_prev, 1'b0, 1'b0);
            y_prev = y_now;
        end
        if (y_prev) deq();
        check("wrap_all_out", W'(exp_out), W'(21));
        check("wrap_empty",   W'(fq.count_o), W'(0));

        // Roll with a same-cycle commit
        enq(W'('hA)); enq(W'('hB)); enq(W'('hC)); enq(W'('hD));
        yumi(); yumi(); yumi();
        deq();
        step(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("roll_deq_data",  fq.fe_queue_o,  W'('hC));
        check("roll_deq_count", W'(fq.count_o), W'(2));
        clr();

        // Roll without commit
        enq(W'('hA)); enq(W'('hB)); enq(W'('hC)); enq(W'('hD));
        yumi(); yumi(); yumi();
        deq();
        step(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("roll_data",  fq.fe_queue_o,  W'('hB));
        check("roll_count", W'(fq.count_o), W'(3));
        clr();

        // Clear beats enqueue, yumi and deq
        for (int i = 1; i <= 5; i++) enq(W'('h20 + i));
        yumi(); yumi(); yumi();
        deq();
        check("clr_pre_count", W'(fq.count_o), W'(4));
        step(1'b1, W'('h77), 1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_v",     W'(fq.fe_queue_v_o),     W'(0));
        check("clr_count", W'(fq.count_o),          W'(0));
        check("clr_ready", W'(fq.fe_queue_ready_o), W'(1));
        enq(W'('h55));
        check("clr_next_data", fq.fe_queue_o,  W'('h55));
        check("clr_next_count", W'(fq.count_o), W'(1));
        clr();

        // Full with everything issued; enq+deq at full
        for (int i = 1; i <= ELS; i++) enq(W'('h30 + i));
        for (int i = 0; i < ELS; i++) yumi();
        check("fullrd_v",     W'(fq.fe_queue_v_o),     W'(0));
        check("fullrd_ready", W'(fq.fe_queue_ready_o), W'(0));
        check("fullrd_count", W'(fq.count_o),          W'(8));
        step(1'b1, W'('h99), 1'b0, 1'b1, 1'b0, 1'b0);
        check("fullrd_deq_ready", W'(fq.fe_queue_ready_o), W'(1));
        check("fullrd_deq_count", W'(fq.count_o),          W'(7));
        check("fullrd_deq_v",     W'(fq.fe_queue_v_o),     W'(0));
        enq(W'('h66));
        check("fullrd_enq_data", fq.fe_queue_o, W'('h66));
        clr();

        // Asynchronous reset between edges
        for (int i = 1; i <= 4; i++) enq(W'('h40 + i));
        check("arst_pre_count", W'(fq.count_o), W'(4));
        #2 rst_n = 1'b0;
        #1;
        check("arst_v",     W'(fq.fe_queue_v_o),     W'(0));
        check("arst_count", W'(fq.count_o),          W'(0));
        check("arst_ready", W'(fq.fe_queue_ready_o), W'(1));
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        d = W'('h42);
        enq(d);
        check("arst_after_data",  fq.fe_queue_o,  W'('h42));
        check("arst_after_count", W'(fq.count_o), W'(1));
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
